bullet_array_sprite: RTL and testbench
======================================

Name: bullet_array_sprite

Overview:
Parametrised multi-bullet sprite generator for the battle box. Tracks NUM_BULLETS circular bullets, each on its own row, moving horizontally and bouncing between X_MIN and X_MAX at a frame-divided rate. Each bullet has an individual alive/dead latch driven by per-bullet collision and cleared by a respawn pulse. Sits beside the player sprite in the VGA pixel pipeline. Emits one registered "bullet pixel on" flag plus status for game logic.

Parameters:
NUM_BULLETS, 4, number of bullets (1..8)
RADIUS, 5, bullet radius in pixels; pixel is on when dx^2+dy^2 <= RADIUS^2
STEP, 6, pixels moved per move event
FRAME_DIV, 3, frames per move event (>=1)
X_MIN, 230, left bounce bound
X_MAX, 410, right bounce bound
X_SPACING, 40, start X of bullet i = X_MIN + i*X_SPACING; must satisfy X_MIN+(NUM_BULLETS-1)*X_SPACING <= X_MAX
Y_BASE, 222, Y centre of bullet 0
Y_PITCH, 16, Y centre of bullet i = Y_BASE + i*Y_PITCH

Ports:
Pclk  in  1  25 MHz pixel clock
reset  in  1  synchronous, active-high
xx  in  10  current pixel x
yy  in  10  current pixel y
aactive  in  1  high during active pixel drawing
isCollision  in  NUM_BULLETS  per-bullet hit, level, sampled every Pclk
respawn  in  1  one-cycle pulse; revives all bullets at start positions
BulletSpriteOn  out  1  registered: current pixel lies on any alive bullet
aliveMask  out  NUM_BULLETS  bit i = bullet i alive
allDead  out  1  high when aliveMask == 0

Behaviour:
- One clock (Pclk); synchronous, active-high reset. All state updates on posedge Pclk.
- Reset values: BulletSpriteOn=0, aliveMask=all 1s, allDead=0, frame divider=0, bullet i X = X_MIN+i*X_SPACING, direction of even i = right, odd i = left.
- Frame tick: xx==639 && yy==479, one cycle per frame.
- Divider: on a frame tick, the counter increments. When it reaches FRAME_DIV-1, it wraps to 0 and raises a move event in that same cycle. FRAME_DIV=1 gives a move event every frame.
- Move event, per bullet, dead bullets included (positions stay in phase):
  - Right: if X+STEP >= X_MAX then X<=X_MAX, dir<=left; else X<=X+STEP.
  - Left: if X < X_MIN+STEP then X<=X_MIN, dir<=right; else X<=X-STEP.
  - X never leaves [X_MIN, X_MAX]. Computation uses 11-bit width, so there is no 10-bit wrap.
- Hit test, per bullet, combinational:
  - dx = xx-X and dy = yy-Yi, as 11-bit signed.
  - Squares and sum are 22-bit unsigned.
  - Early reject when |dx|>RADIUS or |dy|>RADIUS.
- BulletSpriteOn <= aactive && OR_i(alive_i && hit_i). Latency 1 Pclk from xx/yy.
- Alive latch i:
  - isCollision[i]=1 clears alive_i next cycle; it stays dead until respawn or reset.
  - Once cleared, the bullet stops contributing to BulletSpriteOn from the next pixel.
- respawn=1:
  - All alive bits set.
  - Positions and directions reload to reset values.
  - Divider reloads to 0.
- Simultaneous events:
  - respawn together with isCollision[i]: respawn wins, bullet i is alive.
  - respawn together with a move event: respawn wins, no move is applied.
  - reset overrides everything.
- allDead is registered and updates in the same cycle as aliveMask.

Decomposition:
- Shared package (sprite_pkg): SCREEN_X_LAST=639, SCREEN_Y_LAST=479, coordinate width 10, DIR_LEFT/DIR_RIGHT encoding.
- Sub-module bullet_unit: one bullet's X/dir register, alive latch and circle hit test.
  - Inputs: Pclk, reset, move, respawn, collision, xx, yy.
  - Output: hit_on.
  - Generated NUM_BULLETS times. The parent holds the divider, OR-reduce and status outputs.

Test Plan:
- Reset, then scan frame 0 with defaults. At (230,222), bullet 0 centre, BulletSpriteOn=1 one cycle later. At (236,222), dx=6 > 5, it is 0. At (233,226), 9+16=25, it is 1. aactive=0 at (230,222) gives 0.
- Run 3 frame ticks. After the 3rd, bullet 0 X=236 and bullet 1 (start 270, left) X=264. Only 1 and 2 ticks cause no motion.
- Bounce bounds. Bullet 0 from X=404 moving right reaches X=410 and turns left. The next move gives 404. Bullet near X_MIN=230 moving left from X=233 clamps to 230 and turns right.
- Assert isCollision[2] for one cycle. aliveMask=4'b1011 next cycle. Bullet 2's centre pixel then reads BulletSpriteOn=0. Kill all four and allDead=1.
- Same cycle as a move event, assert respawn and isCollision[0]. Result: aliveMask=4'b1111, positions equal reset values, divider=0.
- Assert reset mid-frame while bullets are displaced and dead. Next cycle all outputs and state equal reset values. Set FRAME_DIV=1 and confirm motion on every frame tick.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared screen geometry and direction encoding for the battle-box sprite generators.
package sprite_pkg;

  localparam int COORD_W = 10;
  localparam int CALC_W  = 11;

  localparam logic [COORD_W-1:0] SCREEN_X_LAST = 10'd639;
  localparam logic [COORD_W-1:0] SCREEN_Y_LAST = 10'd479;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/bullet_array_sprite_bullet_unit.sv
// One bullet: bouncing X position, alive latch and circular hit test on a fixed row.
module bullet_unit
  import sprite_pkg::*;
#(
  parameter int   RADIUS   = 5,
  parameter int   STEP     = 6,
  parameter int   X_MIN    = 230,
  parameter int   X_MAX    = 410,
  parameter int   X_START  = 230,
  parameter int   Y_CENTRE = 222,
  parameter dir_e DIR_START = DIR_RIGHT
) (
  input  logic               Pclk,
  input  logic               reset,
  input  logic               move,
  input  logic               respawn,
  input  logic               collision,
  input  logic [COORD_W-1:0] xx,
  input  logic [COORD_W-1:0] yy,
  output logic               hit_on,
  output logic               alive,
  output logic               alive_nxt
);

  localparam logic [CALC_W-1:0] XMIN_C   = CALC_W'(X_MIN);
  localparam logic [CALC_W-1:0] XMAX_C   = CALC_W'(X_MAX);
  localparam logic [CALC_W-1:0] STEP_C   = CALC_W'(STEP);
  localparam logic [CALC_W-1:0] XSTART_C = CALC_W'(X_START);
  localparam logic [CALC_W-1:0] YC_C     = CALC_W'(Y_CENTRE);
  localparam logic [CALC_W-1:0] RAD_C    = CALC_W'(RADIUS);
  localparam logic [21:0]       RAD2_C   = 22'(RADIUS * RADIUS);

  logic [CALC_W-1:0] x_q, x_d;
  dir_e              dir_q, dir_d;
  logic              alive_q, alive_d;

  // Respawn outranks a move landing in the same cycle; bounds clamp and reverse.
  always_comb begin
    x_d   = x_q;
    dir_d = dir_q;
    if (respawn) begin
      x_d   = XSTART_C;
      dir_d = DIR_START;
    end else if (move) begin
      if (dir_q == DIR_RIGHT) begin
        if (x_q + STEP_C >= XMAX_C) begin
          x_d   = XMAX_C;
          dir_d = DIR_LEFT;
        end else begin
          x_d = x_q + STEP_C;
        end
      end else begin
        if (x_q < XMIN_C + STEP_C) begin
          x_d   = XMIN_C;
          dir_d = DIR_RIGHT;
        end else begin
          x_d = x_q - STEP_C;
        end
      end
    end
  end

  always_comb begin
    alive_d = respawn | (alive_q & ~collision);
  end

  always_ff @(posedge Pclk) begin
    if (reset) begin
      x_q     <= XSTART_C;
      dir_q   <= DIR_START;
      alive_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      dir_q   <= dir_d;
      alive_q <= alive_d;
    end
  end

  logic signed [CALC_W-1:0] dx, dy;
  logic        [CALC_W-1:0] adx, ady;
  logic        [21:0]       dx2, dy2, dist2;
  logic                     inCircle;

  // Box reject first so the squared distance only matters near the bullet.
  always_comb begin
    dx       = $signed({1'b0, xx}) - $signed(x_q);
    dy       = $signed({1'b0, yy}) - $signed(YC_C);
    adx      = dx[CALC_W-1] ? (~dx + 11'd1) : dx;
    ady      = dy[CALC_W-1] ? (~dy + 11'd1) : dy;
    dx2      = 22'(adx) * 22'(adx);
    dy2      = 22'(ady) * 22'(ady);
    dist2    = dx2 + dy2;
    inCircle = (adx <= RAD_C) && (ady <= RAD_C) && (dist2 <= RAD2_C);
  end

  assign hit_on    = alive_q & inCircle;
  assign alive     = alive_q;
  assign alive_nxt = alive_d;

endmodule

// File: rtl/bullet_array_sprite.sv
// Multi-bullet sprite: frame divider, per-bullet units and the registered pixel/status outputs.
module bullet_array_sprite
  import sprite_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int RADIUS      = 5,
  parameter int STEP        = 6,
  parameter int FRAME_DIV   = 3,
  parameter int X_MIN       = 230,
  parameter int X_MAX       = 410,
  parameter int X_SPACING   = 40,
  parameter int Y_BASE      = 222,
  parameter int Y_PITCH     = 16
) (
  input  logic                   Pclk,
  input  logic                   reset,
  input  logic [COORD_W-1:0]     xx,
  input  logic [COORD_W-1:0]     yy,
  input  logic                   aactive,
  input  logic [NUM_BULLETS-1:0] isCollision,
  input  logic                   respawn,
  output logic                   BulletSpriteOn,
  output logic [NUM_BULLETS-1:0] aliveMask,
  output logic                   allDead
);

  localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic [DIV_W-1:0]       div_q, div_d;
  logic                   frameTick, moveEvent;
  logic [NUM_BULLETS-1:0] hits, aliveNext;
  logic                   on_q, on_d;
  logic                   allDead_q, allDead_d;

  assign frameTick = (xx == SCREEN_X_LAST) && (yy == SCREEN_Y_LAST);
  assign moveEvent = frameTick && (div_q == DIV_LAST);

  // The wrap cycle itself raises the move event, so FRAME_DIV=1 moves every frame.
  always_comb begin
    div_d = div_q;
    if (respawn) begin
      div_d = '0;
    end else if (frameTick) begin
      div_d = moveEvent ? '0 : DIV_W'(div_q + 1'b1);
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_bullet
    bullet_unit #(
      .RADIUS    (RADIUS),
      .STEP      (STEP),
      .X_MIN     (X_MIN),
      .X_MAX     (X_MAX),
      .X_START   (X_MIN + i * X_SPACING),
      .Y_CENTRE  (Y_BASE + i * Y_PITCH),
      .DIR_START ((i % 2 == 0) ? DIR_RIGHT : DIR_LEFT)
    ) u_bullet (
      .Pclk      (Pclk),
      .reset     (reset),
      .move      (moveEvent),
      .respawn   (respawn),
      .collision (isCollision[i]),
      .xx        (xx),
      .yy        (yy),
      .hit_on    (hits[i]),
      .alive     (aliveMask[i]),
      .alive_nxt (aliveNext[i])
    );
  end

  // allDead looks at next-state alive bits so it lands with aliveMask.
  always_comb begin
    on_d      = aactive && (|hits);
    allDead_d = ~(|aliveNext);
  end

  always_ff @(posedge Pclk) begin
    if (reset) begin
      div_q     <= '0;
      on_q      <= 1'b0;
      allDead_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      on_q      <= on_d;
      allDead_q <= allDead_d;
    end
  end

  assign BulletSpriteOn = on_q;
  assign allDead        = allDead_q;

endmodule

// File: tb/tb_bullet_array_sprite.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares them.
module tb_bullet_array_sprite;

  logic       Pclk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] xx = '0, yy = '0, xx1 = '0, yy1 = '0;
  logic       aactive = 1'b0;
  logic [3:0] isCollision = '0;
  logic       respawn = 1'b0;
  logic       on0, on1, allDead0, allDead1;
  logic [3:0] alive0, alive1;
  logic [3:0] noCollision = '0;

  int cycleCnt = 0;
  int nChecks  = 0;
  int nErrors  = 0;

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sbq[$];

  bullet_array_sprite dut (
    .Pclk(Pclk), .reset(reset), .xx(xx), .yy(yy), .aactive(aactive),
    .isCollision(isCollision), .respawn(respawn),
    .BulletSpriteOn(on0), .aliveMask(alive0), .allDead(allDead0)
  );

  bullet_array_sprite #(.FRAME_DIV(1)) dut1 (
    .Pclk(Pclk), .reset(reset), .xx(xx1), .yy(yy1), .aactive(aactive),
    .isCollision(noCollision), .respawn(respawn),
    .BulletSpriteOn(on1), .aliveMask(alive1), .allDead(allDead1)
  );

  always #20 Pclk = ~Pclk;

  always @(posedge Pclk) cycleCnt <= cycleCnt + 1;

  // Monitor: every output register is visible one negedge after its stimulus cycle.
  initial begin
    forever begin
      @(negedge Pclk);
      while (sbq.size() > 0 && sbq[0].due <= cycleCnt) begin
        exp_t       e;
        logic [7:0] act;
        e = sbq.pop_front();
        case (e.kind)
          0:       act = {7'b0, on0};
          1:       act = {4'b0, alive0};
          2:       act = {7'b0, allDead0};
          default: act = {7'b0, on1};
        endcase
        nChecks++;
        if (e.due != cycleCnt || act !== e.exp) begin
          nErrors++;
          $display("[TB] FAIL %s: got %0h expected %0h (due %0d at %0d)",
                   e.name, act, e.exp, e.due, cycleCnt);
        end
      end
    end
  end

  task automatic checkOutput(input int kind, input logic [7:0] v, input string nm);
    exp_t e;
    e.due  = cycleCnt + 1;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                               input logic [9:0] x1, input logic [9:0] y1,
                               input logic act, input logic [3:0] coll,
                               input logic resp, input logic rst);
    xx = x; yy = y; xx1 = x1; yy1 = y1;
    aactive = act; isCollision = coll; respawn = resp; reset = rst;
    @(negedge Pclk);
  endtask

  task automatic probe(input int x, input int y, input logic act, input logic e, input string nm);
    checkOutput(0, {7'b0, e}, nm);
    applyStimulus(10'(x), 10'(y), 10'd0, 10'd0, act, 4'b0, 1'b0, 1'b0);
  endtask

  task automatic probe1(input int x, input int y, input logic e, input string nm);
    checkOutput(3, {7'b0, e}, nm);
    applyStimulus(10'd0, 10'd0, 10'(x), 10'(y), 1'b1, 4'b0, 1'b0, 1'b0);
  endtask

  // Both edges at +/-RADIUS lit and one past the right edge dark pins the centre exactly.
  task automatic checkPos(input int x, input int y, input string nm);
    probe(x - 5, y, 1'b1, 1'b1, {nm, "_l"});
    probe(x + 5, y, 1'b1, 1'b1, {nm, "_r"});
    probe(x + 6, y, 1'b1, 1'b0, {nm, "_out"});
  endtask

  task automatic checkPos1(input int x, input int y, input string nm);
    probe1(x - 5, y, 1'b1, {nm, "_l"});
    probe1(x + 5, y, 1'b1, {nm, "_r"});
    probe1(x + 6, y, 1'b0, {nm, "_out"});
  endtask

  task automatic tick();
    applyStimulus(10'd639, 10'd479, 10'd639, 10'd479, 1'b0, 4'b0, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 4'b0, 1'b0, 1'b1);
    checkOutput(0, 8'h0, "rst_on");
    checkOutput(1, 8'hF, "rst_alive");
    checkOutput(2, 8'h0, "rst_alldead");
    applyStimulus(10'd230, 10'd222, 10'd0, 10'd0, 1'b1, 4'b0, 1'b0, 1'b1);

    probe(230, 222, 1'b1, 1'b1, "b0_centre");
    probe(236, 222, 1'b1, 1'b0, "b0_dx6");
    probe(233, 226, 1'b1, 1'b1, "b0_r2_edge");
    probe(230, 222, 1'b0, 1'b0, "b0_inactive");
    probe(270, 238, 1'b1, 1'b1, "b1_centre");
    probe(264, 238, 1'b1, 1'b0, "b1_dx6");
    probe1(230, 222, 1'b1, "d1_b0_centre");

    tick();
    checkPos(230, 222, "t1_b0");
    checkPos1(236, 222, "d1_t1_b0");
    tick();
    checkPos(230, 222, "t2_b0");
    tick();
    checkPos(236, 222, "t3_b0");
    checkPos(264, 238, "t3_b1");
    checkPos1(248, 222, "d1_t3_b0");
    checkPos1(252, 238, "d1_t3_b1");

    for (int t = 4; t <= 6; t++) tick();
    checkPos1(234, 238, "d1_m6_b1");
    tick();
    checkPos1(230, 238, "d1_m7_b1_clamp");
    tick();
    checkPos1(236, 238, "d1_m8_b1_turn");
    for (int t = 9; t <= 29; t++) tick();
    checkPos1(404, 222, "d1_m29_b0");
    tick();
    checkPos1(410, 222, "d1_m30_b0_clamp");
    tick();
    checkPos1(404, 222, "d1_m31_b0_turn");
    checkPos(290, 222, "t31_b0");
    checkPos(248, 238, "t31_b1");

    checkOutput(1, 8'hB, "kill2_alive");
    checkOutput(2, 8'h0, "kill2_alldead");
    applyStimulus(10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 4'b0100, 1'b0, 1'b0);
    probe(370, 254, 1'b1, 1'b0, "b2_dead_centre");
    probe(290, 222, 1'b1, 1'b1, "b0_still_on");
    checkOutput(1, 8'h0, "killall_alive");
    checkOutput(2, 8'h1, "killall_alldead");
    applyStimulus(10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 4'b1011, 1'b0, 1'b0);
    probe(290, 222, 1'b1, 1'b0, "b0_dead_centre");

    tick();
    checkOutput(1, 8'hF, "respawn_alive");
    checkOutput(2, 8'h0, "respawn_alldead");
    applyStimulus(10'd639, 10'd479, 10'd639, 10'd479, 1'b0, 4'b0001, 1'b1, 1'b0);
    checkPos(230, 222, "resp_b0");
    checkPos(270, 238, "resp_b1");
    tick();
    tick();
    checkPos(230, 222, "resp_t2_b0");
    tick();
    checkPos(236, 222, "resp_t3_b0");
    checkPos1(248, 222, "d1_resp_t3_b0");

    checkOutput(1, 8'hD, "kill1_alive");
    applyStimulus(10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 4'b0010, 1'b0, 1'b0);
    checkOutput(0, 8'h0, "midrst_on");
    checkOutput(1, 8'hF, "midrst_alive");
    checkOutput(2, 8'h0, "midrst_alldead");
    applyStimulus(10'd236, 10'd222, 10'd0, 10'd0, 1'b1, 4'b0, 1'b0, 1'b1);
    probe(270, 238, 1'b1, 1'b1, "midrst_b1_revived");
    checkPos(230, 222, "midrst_b0");
    tick();
    checkPos1(236, 222, "d1_midrst_t1_b0");
    tick();
    checkPos(230, 222, "midrst_t2_b0");
    tick();
    checkPos(236, 222, "midrst_t3_b0");

    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge Pclk);
    if (sbq.size() > 0) begin
      nErrors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
